// File: rtl/instr_encoder.sv
// Field-wise instruction encoder. Packs opcode/register/immediate fields into 16-bit
// words and streams them, tagged with sequential program addresses, through a 2-entry FIFO.
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int PROG_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fmt,
  input  logic [3:0]        opcode,
  input  logic [2:0]        rs1,
  input  logic [2:0]        rs2,
  input  logic [2:0]        rd,
  input  logic [5:0]        imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              prog_full
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(PROG_DEPTH);

  state_t             state, state_nxt;
  logic [15:0]        enc_word;
  logic [1:0]         fifo_cnt;
  logic [15:0]        slot_word;
  logic [ADDR_W-1:0]  slot_addr;
  logic [ADDR_W-1:0]  addr_ctr;
  logic               push, pop, enter_load;

  always_comb begin
    enc_word = fmt ? {opcode, rs1, rs2, imm} : {opcode, rs1, rs2, rd, 3'b000};
  end

  assign in_ready  = (state == LOAD) && (fifo_cnt < 2'd2) && (word_count < DEPTH_C);
  assign out_valid = (fifo_cnt != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign busy      = (state == LOAD);
  assign prog_full = (state == DONE);

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (word_count == DEPTH_C && fifo_cnt == 2'd0) state_nxt = DONE;
      DONE:    if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_load = (state_nxt == LOAD) && (state != LOAD);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_ctr   <= '0;
      word_count <= '0;
    end else begin
      state <= state_nxt;
      if (enter_load) begin
        addr_ctr   <= '0;
        word_count <= '0;
      end else if (push) begin
        addr_ctr   <= addr_ctr + 1'b1;
        word_count <= word_count + 1'b1;
      end
    end
  end

  // Head register doubles as the output; it simply holds its value once the FIFO drains.
  // NOTE: the two FIFO slots are plain registers, so resetting them is cheap and makes out_word/out_addr defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt  <= 2'd0;
      out_word  <= '0;
      out_addr  <= '0;
      slot_word <= '0;
      slot_addr <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            out_word <= enc_word;
            out_addr <= addr_ctr;
          end else begin
            slot_word <= enc_word;
            slot_addr <= addr_ctr;
          end
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          if (fifo_cnt == 2'd2) begin
            out_word <= slot_word;
            out_addr <= slot_addr;
          end
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        // Push with pop only happens at count 1 (push needs <2, pop needs >0).
        2'b11: begin
          out_word <= enc_word;
          out_addr <= addr_ctr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a queue-based model checked every cycle,
// plus directed scenarios with hand-computed expected words and addresses.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, fmt = 1'b0, out_ready = 1'b0;
  logic [3:0] opcode = '0;
  logic [2:0] rs1 = '0, rs2 = '0, rd = '0;
  logic [5:0] imm = '0;

  logic        in_ready_a, out_valid_a, busy_a, prog_full_a;
  logic [15:0] out_word_a;
  logic [7:0]  out_addr_a;
  logic [8:0]  word_count_a;
  logic        in_ready_b, out_valid_b, busy_b, prog_full_b;
  logic [15:0] out_word_b;
  logic [1:0]  out_addr_b;
  logic [2:0]  word_count_b;

  instr_encoder #(.ADDR_W(8), .PROG_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
    .fmt(fmt), .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_word(out_word_a),
    .out_addr(out_addr_a), .word_count(word_count_a), .busy(busy_a), .prog_full(prog_full_a)
  );

  // Narrow-address instance: its address counter must wrap modulo 4.
  instr_encoder #(.ADDR_W(2), .PROG_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
    .fmt(fmt), .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_word(out_word_b),
    .out_addr(out_addr_b), .word_count(word_count_b), .busy(busy_b), .prog_full(prog_full_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {logic [15:0] word; int addr;} ent_t;
  ent_t        q[$];
  int          m_state = 0;  // 0 idle, 1 load, 2 done
  int          m_wc = 0, m_addr = 0, m_last_addr = 0;
  logic [15:0] m_last_word = '0;

  function automatic logic [15:0] model_enc();
    int v;
    v = opcode * 4096 + rs1 * 512 + rs2 * 64 + (fmt ? int'(imm) : rd * 8);
    return 16'(v);
  endfunction

  function automatic bit m_in_ready();
    return (m_state == 1) && (q.size() < 2) && (m_wc < DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; q.delete(); m_wc = 0; m_addr = 0; m_last_word = '0; m_last_addr = 0;
    end else begin
      bit   pu, po, go_load, go_done;
      ent_t e;
      pu      = in_valid && m_in_ready();
      po      = (q.size() > 0) && out_ready;
      go_load = (m_state != 1) && start;
      go_done = (m_state == 1) && (m_wc == DEPTH) && (q.size() == 0);
      e.word  = model_enc();
      e.addr  = m_addr;
      if (po) void'(q.pop_front());
      if (pu) begin
        q.push_back(e);
        m_addr++;
        m_wc++;
      end
      if (go_load) begin
        m_state = 1; m_wc = 0; m_addr = 0;
      end else if (go_done) begin
        m_state = 2;
      end
      if (q.size() > 0) begin
        m_last_word = q[0].word;
        m_last_addr = q[0].addr;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("a.in_ready",   in_ready_a,   m_in_ready());
      check("a.out_valid",  out_valid_a,  q.size() > 0);
      check("a.out_word",   out_word_a,   m_last_word);
      check("a.out_addr",   out_addr_a,   m_last_addr % 256);
      check("a.word_count", word_count_a, m_wc);
      check("a.busy",       busy_a,       m_state == 1);
      check("a.prog_full",  prog_full_a,  m_state == 2);
      check("b.in_ready",   in_ready_b,   m_in_ready());
      check("b.out_valid",  out_valid_b,  q.size() > 0);
      check("b.out_word",   out_word_b,   m_last_word);
      check("b.out_addr",   out_addr_b,   m_last_addr % 4);
      check("b.word_count", word_count_b, m_wc);
      check("b.prog_full",  prog_full_b,  m_state == 2);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic f, input logic [3:0] op, input logic [2:0] a,
                            input logic [2:0] b, input logic [2:0] d, input logic [5:0] im);
    fmt = f; opcode = op; rs1 = a; rs2 = b; rd = d; imm = im;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Holds in_valid until one handshake; bounded so a stuck in_ready fails instead of hanging.
  task automatic send(input string name);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready_a;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check({name, ".accepted"}, acc, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_cnt;
    // Reset values
    repeat (3) tick();
    check("rst.out_valid",  out_valid_a,  0);
    check("rst.in_ready",   in_ready_a,   0);
    check("rst.out_word",   out_word_a,   16'h0000);
    check("rst.out_addr",   out_addr_a,   0);
    check("rst.word_count", word_count_a, 0);
    check("rst.busy",       busy_a,       0);
    check("rst.prog_full",  prog_full_a,  0);
    rst_n = 1'b1;
    tick();

    // R-type then I-type, out_ready high
    out_ready = 1'b1;
    pulse_start();
    check("t1.busy", busy_a, 1);
    set_fields(1'b0, 4'h3, 3'd1, 3'd2, 3'd5, 6'h3F);
    send("t1.r");
    check("t1.out_valid",  out_valid_a,  1);
    check("t1.out_word",   out_word_a,   16'h32A8);
    check("t1.out_addr",   out_addr_a,   0);
    check("t1.word_count", word_count_a, 1);
    set_fields(1'b1, 4'hA, 3'd7, 3'd0, 3'd7, 6'h2D);
    send("t2.i");
    check("t2.out_word",   out_word_a,   16'hAE2D);
    check("t2.out_addr",   out_addr_a,   1);
    check("t2.word_count", word_count_a, 2);

    // Backpressure: FIFO fills at 2, third word waits for the first pop
    do_reset();
    pulse_start();
    set_fields(1'b0, 4'h1, 3'd1, 3'd1, 3'd1, 6'h00);
    send("t3.w0");
    set_fields(1'b1, 4'h2, 3'd2, 3'd3, 3'd0, 6'h05);
    send("t3.w1");
    set_fields(1'b0, 4'h4, 3'd3, 3'd4, 3'd6, 6'h00);
    in_valid = 1'b1;
    repeat (3) tick();
    check("t3.full_in_ready", in_ready_a, 0);
    check("t3.head_w0",       out_word_a, 16'h1248);
    out_ready = 1'b1;
    tick();
    check("t3.head_w1",     out_word_a, 16'h24C5);
    check("t3.addr_w1",     out_addr_a, 1);
    check("t3.ready_again", in_ready_a, 1);
    tick();
    in_valid = 1'b0;
    check("t3.head_w2", out_word_a,   16'h4730);
    check("t3.addr_w2", out_addr_a,   2);
    check("t3.wc",      word_count_a, 3);
    tick();
    check("t3.drained",   out_valid_a, 0);
    check("t3.held_word", out_word_a,  16'h4730);

    // Session limit: offer 8 words, exactly 4 accepted, then DONE
    do_reset();
    pulse_start();
    out_ready = 1'b1;
    acc_cnt = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_fields(i[0], 4'(i + 5), 3'(i), 3'(7 - i), 3'(i + 2), 6'(i * 9));
      @(negedge clk);
      if (in_ready_a) acc_cnt++;
      tick();
    end
    in_valid = 1'b0;
    check("t4.accepted",    acc_cnt,      4);
    check("t4.prog_full",   prog_full_a,  1);
    check("t4.busy",        busy_a,       0);
    check("t4.wc",          word_count_a, 4);
    check("t4.in_ready",    in_ready_a,   0);
    check("t4.last_addr_a", out_addr_a,   3);
    check("t4.last_addr_b", out_addr_b,   3);
    tick();
    check("t4.wc_held", word_count_a, 4);

    // Restart from DONE: addresses restart at 0 (narrow instance goes 3 -> 0)
    pulse_start();
    check("t5.busy", busy_a,       1);
    check("t5.wc",   word_count_a, 0);
    set_fields(1'b1, 4'hF, 3'd0, 3'd0, 3'd0, 6'h01);
    send("t5.w0");
    check("t5.word",   out_word_a, 16'hF001);
    check("t5.addr_a", out_addr_a, 0);
    check("t5.addr_b", out_addr_b, 0);

    // Async reset with two words buffered
    out_ready = 1'b0;
    set_fields(1'b0, 4'h6, 3'd2, 3'd2, 3'd2, 6'h00);
    send("t6.w1");
    check("t6.full", in_ready_a, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6.out_valid", out_valid_a,  0);
    check("t6.in_ready",  in_ready_a,   0);
    check("t6.busy",      busy_a,       0);
    check("t6.wc",        word_count_a, 0);
    check("t6.out_word",  out_word_a,   16'h0000);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("t6.idle_busy", busy_a,       0);
    check("t6.idle_wc",   word_count_a, 0);
    check("t6.idle_rdy",  in_ready_a,   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
